// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus between fetch (master) and the registered immediate generator (slave).
// Carries the raw instruction with its tag in, and the decoded immediate with the same tag out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic [2:0]       imm_fmt;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, instruction, in_tag, out_ready,
    input  in_ready, out_valid, imm_ext, imm_fmt, illegal, out_tag
  );

  modport slave (
    input  in_valid, instruction, in_tag, out_ready,
    output in_ready, out_valid, imm_ext, imm_fmt, illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode of the incoming instruction,
// registered into a two-entry (main + skid) valid/ready stage with a registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam bit         IS64    = (XLEN == 64);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  // ---------------- decode ----------------
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] imm_i;

  assign instr    = bus.instruction;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_i    = XLEN'($signed(instr[31:20]));

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    case (opcode)
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
        dec_imm = imm_i;
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
      end
      7'b0010011: begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        if (is_shift) begin
          // shamt field is one bit wider on RV64
          dec_imm = IS64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          dec_imm = imm_i;
        end
      end
      7'b0011011: begin
        if (IS64) begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
          dec_imm = is_shift ? XLEN'(instr[24:20]) : imm_i;
        end
      end
      7'b0100011: begin
        dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
      end
      7'b1100011: begin
        dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
      end
      7'b1101111: begin
        dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
      7'b0111011: begin
        if (IS64) begin
          dec_fmt = FMT_R;
          dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------- two-entry stage ----------------
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  logic [2:0]       main_fmt_q, main_fmt_d;
  logic             main_ill_q, main_ill_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             in_fire;
  logic             out_fire;

  // An input offered during a flush is never accepted.
  assign in_fire  = bus.in_valid && in_ready_q && !flush;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    main_tag_d = main_tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
          main_ill_d = dec_ill;
          main_tag_d = bus.in_tag;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
          main_ill_d = dec_ill;
          main_tag_d = bus.in_tag;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_ill_d = dec_ill;
          skid_tag_d = bus.in_tag;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_imm_d = skid_imm_q;
          main_fmt_d = skid_fmt_q;
          main_ill_d = skid_ill_q;
          main_tag_d = skid_tag_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A transfer in the flush cycle still completes; the flush only drops what remains.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_imm_q  <= '0;
      main_fmt_q  <= '0;
      main_ill_q  <= 1'b0;
      main_tag_q  <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= '0;
      skid_ill_q  <= 1'b0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_imm_q  <= main_imm_d;
      main_fmt_q  <= main_fmt_d;
      main_ill_q  <= main_ill_d;
      main_tag_q  <= main_tag_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm_ext   = main_imm_q;
  assign bus.imm_fmt   = main_fmt_q;
  assign bus.illegal   = main_ill_q;
  assign bus.out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and checks both
// against a queue-based reference of accepted instructions plus an arithmetic decoder.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] ins;
  logic [15:0] tag;
  logic        out_ready;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(16)) b32();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(16)) b64();

  assign b32.in_valid = in_valid;    assign b64.in_valid = in_valid;
  assign b32.instruction = ins;      assign b64.instruction = ins;
  assign b32.in_tag = tag;           assign b64.in_tag = tag;
  assign b32.out_ready = out_ready;  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(16)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(16)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decoder: field values combined arithmetically, sign applied by subtraction.
  function automatic void ref_decode(input logic [31:0] x, input bit is64,
                                     output longint imm, output logic [2:0] fmt, output bit ill);
    longint sgn;
    bit shift;
    sgn   = x[31] ? 64'd1 : 64'd0;
    shift = (x[14:12] == 3'd1) || (x[14:12] == 3'd5);
    imm = 0; fmt = 3'd7; ill = 1'b1;
    case (x[6:0])
      7'h03, 7'h0F, 7'h67, 7'h73: begin
        fmt = 1; ill = 0; imm = longint'(x[31:20]) - sgn * 4096;
      end
      7'h13: begin
        fmt = 1; ill = 0;
        if (shift) imm = is64 ? longint'(x[25:20]) : longint'(x[24:20]);
        else imm = longint'(x[31:20]) - sgn * 4096;
      end
      7'h1B: if (is64) begin
        fmt = 1; ill = 0;
        if (shift) imm = longint'(x[24:20]);
        else imm = longint'(x[31:20]) - sgn * 4096;
      end
      7'h23: begin
        fmt = 2; ill = 0; imm = longint'(x[31:25]) * 32 + longint'(x[11:7]) - sgn * 4096;
      end
      7'h63: begin
        fmt = 3; ill = 0;
        imm = sgn * 4096 + longint'(x[7]) * 2048 + longint'(x[30:25]) * 32
              + longint'(x[11:8]) * 2 - sgn * 8192;
      end
      7'h37, 7'h17: begin
        fmt = 4; ill = 0; imm = longint'(x[31:12]) * 4096 - sgn * 64'h1_0000_0000;
      end
      7'h6F: begin
        fmt = 5; ill = 0;
        imm = sgn * (1 << 20) + longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048
              + longint'(x[30:21]) * 2 - sgn * (1 << 21);
      end
      7'h33: begin fmt = 0; ill = 0; end
      7'h3B: if (is64) begin fmt = 0; ill = 0; end
      default: ;
    endcase
  endfunction

  typedef struct { logic [31:0] ins; logic [15:0] tag; } ent_t;
  ent_t        q[$];
  logic [15:0] seen[$];
  bit          mon_en = 1'b0;

  // Scoreboard: checks outputs every cycle, then applies what the coming edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      longint     imm_m;
      logic [2:0] fmt_m;
      bit         ill_m;
      bit         in_fire;
      bit         out_fire;
      chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
      chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
      chk("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
      chk("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        ref_decode(q[0].ins, 1'b0, imm_m, fmt_m, ill_m);
        chk("sb_imm32", 64'(b32.imm_ext), 64'(imm_m[31:0]));
        chk("sb_fmt32", 64'(b32.imm_fmt), 64'(fmt_m));
        chk("sb_ill32", 64'(b32.illegal), 64'(ill_m));
        chk("sb_tag32", 64'(b32.out_tag), 64'(q[0].tag));
        ref_decode(q[0].ins, 1'b1, imm_m, fmt_m, ill_m);
        chk("sb_imm64", b64.imm_ext, imm_m);
        chk("sb_fmt64", 64'(b64.imm_fmt), 64'(fmt_m));
        chk("sb_ill64", 64'(b64.illegal), 64'(ill_m));
        chk("sb_tag64", 64'(b64.out_tag), 64'(q[0].tag));
      end
      in_fire  = in_valid && (q.size() < 2) && !flush;
      out_fire = (q.size() > 0) && out_ready;
      if (reset) begin
        q.delete();
      end else begin
        if (out_fire) begin
          seen.push_back(q[0].tag);
          void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (in_fire) q.push_back('{ins, tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_state(input string pfx);
    chk({pfx, "_out_valid32"}, 64'(b32.out_valid), 64'd0);
    chk({pfx, "_in_ready32"}, 64'(b32.in_ready), 64'd1);
    chk({pfx, "_imm32"}, 64'(b32.imm_ext), 64'd0);
    chk({pfx, "_fmt32"}, 64'(b32.imm_fmt), 64'd0);
    chk({pfx, "_ill32"}, 64'(b32.illegal), 64'd0);
    chk({pfx, "_tag32"}, 64'(b32.out_tag), 64'd0);
    chk({pfx, "_out_valid64"}, 64'(b64.out_valid), 64'd0);
    chk({pfx, "_in_ready64"}, 64'(b64.in_ready), 64'd1);
    chk({pfx, "_imm64"}, b64.imm_ext, 64'd0);
    chk({pfx, "_fmt64"}, 64'(b64.imm_fmt), 64'd0);
    chk({pfx, "_ill64"}, 64'(b64.illegal), 64'd0);
    chk({pfx, "_tag64"}, 64'(b64.out_tag), 64'd0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm32; logic [2:0] fmt32; logic ill32;
    logic [63:0] imm64; logic [2:0] fmt64; logic ill64;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [6:0] ops [14] = '{7'h03, 7'h0F, 7'h67, 7'h73, 7'h13, 7'h1B, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 14);
    if (k < 14) r[6:0] = ops[k];
    return r;
  endfunction

  initial begin
    bit acc;
    vecs[0]  = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    vecs[1]  = '{32'h00512423, 32'h00000008, 3'd2, 1'b0, 64'h0000000000000008, 3'd2, 1'b0};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[4]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0};
    vecs[5]  = '{32'h00509093, 32'h00000005, 3'd1, 1'b0, 64'h0000000000000005, 3'd1, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1};
    vecs[7]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[8]  = '{32'h03F09093, 32'h0000001F, 3'd1, 1'b0, 64'h000000000000003F, 3'd1, 1'b0};
    vecs[9]  = '{32'h0000101B, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[10] = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[11] = '{32'h0000003B, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[12] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[13] = '{32'h40505093, 32'h00000005, 3'd1, 1'b0, 64'h0000000000000005, 3'd1, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; ins = '0; tag = '0; out_ready = 1'b0;
    step();
    step();
    chk_zero_state("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed table, back-to-back with out_ready high: result one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        $display("vec %0d ins=%h imm32=%h imm64=%h fmt=%0d/%0d", i - 1, vecs[i-1].ins,
                 b32.imm_ext, b64.imm_ext, b32.imm_fmt, b64.imm_fmt);
        chk("vec_valid", 64'(b32.out_valid), 64'd1);
        chk("vec_tag", 64'(b32.out_tag), 64'(i + 99));
        chk("vec_imm32", 64'(b32.imm_ext), 64'(vecs[i-1].imm32));
        chk("vec_fmt32", 64'(b32.imm_fmt), 64'(vecs[i-1].fmt32));
        chk("vec_ill32", 64'(b32.illegal), 64'(vecs[i-1].ill32));
        chk("vec_imm64", b64.imm_ext, vecs[i-1].imm64);
        chk("vec_fmt64", 64'(b64.imm_fmt), 64'(vecs[i-1].fmt64));
        chk("vec_ill64", 64'(b64.illegal), 64'(vecs[i-1].ill64));
      end
      if (i < NV) begin
        in_valid = 1'b1; ins = vecs[i].ins; tag = 16'(i + 100);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    step();

    // Backpressure: tags 1,2 fill the stage, tag 3 waits, all drain in order.
    seen.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = rand_instr(); tag = 16'd1; step();
    ins = rand_instr(); tag = 16'd2; step();
    chk("bp_in_ready32", 64'(b32.in_ready), 64'd0);
    chk("bp_in_ready64", 64'(b64.in_ready), 64'd0);
    ins = rand_instr(); tag = 16'd3; step();
    step();
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      acc = in_valid && b32.in_ready;
      step();
    end
    chk("bp_tag3_accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (4) step();
    $display("backpressure drained %0d entries", seen.size());
    chk("bp_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("bp_order0", 64'(seen[0]), 64'd1);
      chk("bp_order1", 64'(seen[1]), 64'd2);
      chk("bp_order2", 64'(seen[2]), 64'd3);
    end

    // Flush with a full stage and a valid input in the same cycle.
    seen.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = rand_instr(); tag = 16'd10; step();
    ins = rand_instr(); tag = 16'd11; step();
    ins = rand_instr(); tag = 16'd12; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid32", 64'(b32.out_valid), 64'd0);
    chk("flush_in_ready32", 64'(b32.in_ready), 64'd1);
    chk("flush_out_valid64", 64'(b64.out_valid), 64'd0);
    chk("flush_in_ready64", 64'(b64.in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; ins = rand_instr(); tag = 16'd13; step();
    in_valid = 1'b0;
    repeat (2) step();
    $display("flush: %0d entries after flush", seen.size());
    chk("flush_count", 64'(seen.size()), 64'd1);
    if (seen.size() == 1) chk("flush_survivor", 64'(seen[0]), 64'd13);

    // One-cycle reset mid-stream, then a fresh instruction.
    out_ready = 1'b0;
    in_valid = 1'b1; ins = rand_instr(); tag = 16'd20; step();
    ins = rand_instr(); tag = 16'd21; step();
    reset = 1'b1; ins = rand_instr(); tag = 16'd22; step();
    reset = 1'b0; in_valid = 1'b0;
    chk_zero_state("midreset");
    out_ready = 1'b1;
    in_valid = 1'b1; ins = 32'hFFC12083; tag = 16'd23; step();
    in_valid = 1'b0;
    $display("post-reset out_valid=%0d tag=%0d", b32.out_valid, b32.out_tag);
    chk("postreset_valid", 64'(b32.out_valid), 64'd1);
    chk("postreset_tag", 64'(b32.out_tag), 64'd23);
    chk("postreset_imm64", b64.imm_ext, 64'hFFFFFFFFFFFFFFFC);
    step();

    // Random traffic with backpressure and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ins       = rand_instr();
      tag       = tag + 16'd1;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty32", 64'(b32.out_valid), 64'd0);
    chk("drain_empty64", 64'(b64.out_valid), 64'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount) plus a format code and an illegal-opcode flag.
- One valid/ready pipeline stage with a skid buffer, so `in_ready` is a registered signal.
- Sits between instruction fetch and the register-file/ALU control path; supports pipeline flush on branch redirect.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  drop all buffered entries; synchronous
- in_valid  input  1  instruction present
- in_ready  output  1  block can accept; registered
- instruction  input  32  raw instruction
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- imm_ext  output  XLEN  extended immediate
- imm_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- illegal  output  1  opcode not supported
- out_tag  output  TAG_W  tag of the instruction on the output

Behaviour:
- Reset: `out_valid`=0, `in_ready`=1, `imm_ext`=0, `imm_fmt`=0, `illegal`=0, `out_tag`=0; skid buffer empty.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Latency: 1 cycle from input accept to `out_valid`. Throughput: 1 per cycle when `out_ready`=1.
  - Order is strictly preserved.
- Buffer states (two entries, main + skid):
  - EMPTY: out invalid, skid empty.
  - ONE: out valid, skid empty.
  - FULL: out valid, skid full, `in_ready`=0.
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on output transfer with no input.
  - ONE stays ONE on simultaneous input and output transfer.
  - ONE -> FULL on input accept while `out_ready`=0.
  - FULL -> ONE on output transfer: the skid entry moves to the output register.
- Outputs are held stable while `out_valid`=1 and `out_ready`=0.
- Decode is combinational on the input and registered on accept.
- Opcode mapping:
  - 0000011, 0001111, 1100111, 1110011 -> I: sign-extend `instr[31:20]`.
  - 0010011 -> I. When funct3 is 001 or 101, the immediate is the zero-extended shamt: `instr[24:20]` for XLEN=32, `instr[25:20]` for XLEN=64. Otherwise sign-extend `instr[31:20]`.
  - 0011011 (OP-IMM-32):
    - XLEN=64: I format; shift forms use zero-extended `instr[24:20]`.
    - XLEN=32: illegal.
  - 0100011 -> S: sign-extend {`instr[31:25]`, `instr[11:7]`}.
  - 1100011 -> B: sign-extend {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
  - 0110111, 0010111 -> U: {`instr[31:12]`, 12'b0}, sign-extended from bit 31 to XLEN.
  - 1101111 -> J: sign-extend {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
  - 0110011, and 0111011 when XLEN=64 -> R: `imm_ext`=0, `illegal`=0.
  - Any other opcode -> `imm_ext`=0, `imm_fmt`=7, `illegal`=1. The entry is still delivered and never dropped.
- Flush:
  - Next cycle: `out_valid`=0, skid empty, `in_ready`=1.
  - An input presented in the flush cycle is discarded even if `in_valid`=1.
  - Flush in the same cycle as an output transfer: the transfer completes, then the flush takes effect.
- Reset mid-operation has the same effect as flush and additionally zeroes the data registers. Reset has priority over flush.

Test Plan:
- XLEN=32, stream `0xFFC12083` (lw), `0x00512423` (sw), `0xFE000CE3` (beq), `out_ready`=1 -> `imm_ext` 0xFFFFFFFC/I, 0x00000008/S, 0xFFFFFFF8/B on three consecutive cycles, each 1 cycle after accept.
- XLEN=32, `0x123450B7` (lui), `0x001000EF` (jal), `0x00509093` (slli 5), `0x0000007F` -> 0x12345000/U, 0x00000800/J, 0x00000005/I, 0x00000000 with `imm_fmt`=7 and `illegal`=1.
- XLEN=64, `0x800000B7` (lui 0x80000) -> `imm_ext`=0xFFFFFFFF80000000. `0x03F09093` (slli 63) -> 0x000000000000003F. `0x0000101B` -> I format, not illegal.
- Backpressure: `out_ready`=0 for 4 cycles with tags 1, 2, 3 offered back-to-back -> tags 1 and 2 accepted, `in_ready`=0 from the cycle after the 2nd accept. Raise `out_ready` -> tags 1, 2, 3 emerge in order with no duplicates.
- Flush with FULL buffer while `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and no flushed tag ever appears.
- Reset asserted mid-stream for 1 cycle -> all outputs 0 and `in_ready`=1 on the following cycle. The first post-reset instruction appears 1 cycle after accept.
